// File: rtl/seg_scan_if.sv
// Handshake bundle between the display-data source and the 7-segment scan controller.
// The data source uses the master modport; the scan controller uses the slave modport.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   pos_out;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic                    frame_done;

    modport master (
        output en, digits, dp, blank,
        input  pos_out, seg_out, dp_out, frame_done
    );

    modport slave (
        input  en, digits, dp, blank,
        output pos_out, seg_out, dp_out, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with refresh prescaler, dead time and frame snapshot.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to suppress leading zero digits at each snapshot.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIV            = 50000,
    parameter int GAP_CYCLES     = 16,
    parameter int ACTIVE_LOW_SEG = 0,
    parameter int ACTIVE_LOW_POS = 0
) (
    input logic       clk,
    input logic       rst_n,
    seg_scan_if.slave bus
);
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]      SHOW_LAST = CNT_W'(DIV - GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] POS_OFF   = {NUM_DIGITS{ACTIVE_LOW_POS != 0}};
    localparam logic [6:0]            SEG_OFF   = {7{ACTIVE_LOW_SEG != 0}};
    localparam logic                  DP_OFF    = (ACTIVE_LOW_SEG != 0);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [4*NUM_DIGITS-1:0] snap_digits_reg;
    logic [NUM_DIGITS-1:0]   snap_dp_reg;
    logic [NUM_DIGITS-1:0]   snap_blank_reg;
    logic [NUM_DIGITS-1:0]   pos_reg;
    logic [6:0]              seg_reg;
    logic                    dp_reg;
    logic                    frame_done_reg;

    logic [3:0]              snap_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   slot_onehot;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   snap_blank_next;
    logic                    slot_dark;
    logic                    slot_dp;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign snap_nib[gi]    = snap_digits_reg[4*gi +: 4];
            assign slot_onehot[gi] = (idx_reg == IDX_W'(gi));
`ifdef SEG_LEADING_ZERO_BLANK_EN
            // A digit is a leading zero when it and every digit above it are zero.
            if (gi == 0) begin : g_keep
                assign lz_mask[gi] = 1'b0;
            end else begin : g_lz
                assign lz_mask[gi] = (bus.digits[4*NUM_DIGITS-1:4*gi] == '0);
            end
`else
            assign lz_mask[gi] = 1'b0;
`endif
        end
    endgenerate

    // A lit decimal point keeps a suppressed leading zero visible.
    assign snap_blank_next = bus.blank | (lz_mask & ~bus.dp);

    assign slot_dark = |(slot_onehot & snap_blank_reg);
    assign slot_dp   = |(slot_onehot & snap_dp_reg);

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            idx_reg         <= '0;
            snap_digits_reg <= '0;
            snap_dp_reg     <= '0;
            snap_blank_reg  <= '0;
            pos_reg         <= POS_OFF;
            seg_reg         <= SEG_OFF;
            dp_reg          <= DP_OFF;
            frame_done_reg  <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;

            // Outputs track the state one cycle late, so segments change only with positions dark.
            if (state_reg == SHOW && !slot_dark) begin
                pos_reg <= POS_OFF ^ slot_onehot;
                seg_reg <= SEG_OFF ^ hex_decode(snap_nib[idx_reg]);
                dp_reg  <= DP_OFF ^ slot_dp;
            end else begin
                pos_reg <= POS_OFF;
                seg_reg <= SEG_OFF;
                dp_reg  <= DP_OFF;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.en) begin
                        state_reg       <= SHOW;
                        cnt_reg         <= '0;
                        idx_reg         <= '0;
                        snap_digits_reg <= bus.digits;
                        snap_dp_reg     <= bus.dp;
                        snap_blank_reg  <= snap_blank_next;
                    end
                end
                SHOW, GAP: begin
                    if (!bus.en) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= SHOW;
                        cnt_reg   <= '0;
                        if (idx_reg == IDX_LAST) begin
                            idx_reg         <= '0;
                            frame_done_reg  <= 1'b1;
                            snap_digits_reg <= bus.digits;
                            snap_dp_reg     <= bus.dp;
                            snap_blank_reg  <= snap_blank_next;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        // With no dead time SHOW_LAST equals CNT_LAST and is handled above.
                        if (cnt_reg == SHOW_LAST) begin
                            state_reg <= GAP;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.pos_out    = pos_reg;
    assign bus.seg_out    = seg_reg;
    assign bus.dp_out     = dp_reg;
    assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: an active-high and an active-low instance share stimulus and are
// checked every cycle against a frame-position model, plus directed literal checkpoints.
module tb_seg_scan_ctrl;
    localparam int ND    = 4;
    localparam int DV    = 8;
    localparam int GP    = 2;
    localparam int FRAME = ND * DV;
    localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(ND)) bus_h ();
    seg_scan_if #(.NUM_DIGITS(ND)) bus_l ();

    assign bus_l.en     = bus_h.en;
    assign bus_l.digits = bus_h.digits;
    assign bus_l.dp     = bus_h.dp;
    assign bus_l.blank  = bus_h.blank;

    seg_scan_ctrl #(
        .NUM_DIGITS(ND), .DIV(DV), .GAP_CYCLES(GP), .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_POS(0)
    ) dut_h (
        .clk(clk), .rst_n(rst_n), .bus(bus_h)
    );

    seg_scan_ctrl #(
        .NUM_DIGITS(ND), .DIV(DV), .GAP_CYCLES(GP), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_POS(1)
    ) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(bus_l)
    );

    // Model: frame position counter and per-frame snapshot.
    bit         m_active = 1'b0;
    int         m_p      = 0;
    int         m_nib [ND];
    bit         m_dp  [ND];
    bit         m_bl  [ND];
    int         m_slot, m_off;
    logic [3:0] e_pos;
    logic [6:0] e_seg;
    logic       e_dp, e_fd;
    bit         e_segv;

    task automatic m_load();
`ifdef SEG_LEADING_ZERO_BLANK_EN
        bit zrun = 1'b1;
`endif
        for (int k = ND - 1; k >= 0; k--) begin
            m_nib[k] = int'(bus_h.digits[4*k +: 4]);
            m_dp[k]  = bus_h.dp[k];
            m_bl[k]  = bus_h.blank[k];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            zrun = zrun && (m_nib[k] == 0);
            if (k != 0 && zrun && !m_dp[k]) m_bl[k] = 1'b1;
`endif
        end
    endtask

    always @(posedge clk) begin
        e_pos  = 4'b0000;
        e_seg  = 7'h00;
        e_dp   = 1'b0;
        e_fd   = 1'b0;
        e_segv = 1'b1;
        if (!rst_n) begin
            m_active = 1'b0;
            m_p      = 0;
        end else if (m_active) begin
            m_slot = m_p / DV;
            m_off  = m_p % DV;
            if (m_off < DV - GP) begin
                if (m_bl[m_slot]) begin
                    e_segv = 1'b0;
                end else begin
                    e_pos = 4'(1 << m_slot);
                    e_seg = HEX7[m_nib[m_slot]];
                    e_dp  = m_dp[m_slot];
                end
            end
            if (!bus_h.en) begin
                m_active = 1'b0;
            end else begin
                m_p++;
                if (m_p == FRAME) begin
                    m_p  = 0;
                    e_fd = 1'b1;
                    m_load();
                end
            end
        end else if (bus_h.en) begin
            m_active = 1'b1;
            m_p      = 0;
            m_load();
        end

        #1;
        n_cmp++;
        if (bus_h.pos_out !== e_pos || bus_h.frame_done !== e_fd ||
            (e_segv && (bus_h.seg_out !== e_seg || bus_h.dp_out !== e_dp))) begin
            n_fail++;
            $display("FAIL cycle_high t=%0t: got pos=%b seg=%h dp=%b fd=%b, expected pos=%b seg=%h dp=%b fd=%b (seg checked=%0d)",
                     $time, bus_h.pos_out, bus_h.seg_out, bus_h.dp_out, bus_h.frame_done,
                     e_pos, e_seg, e_dp, e_fd, e_segv);
        end
        n_cmp++;
        if (bus_l.pos_out !== ~e_pos || bus_l.frame_done !== e_fd ||
            (e_segv && (bus_l.seg_out !== (e_seg ^ 7'h7F) || bus_l.dp_out !== ~e_dp))) begin
            n_fail++;
            $display("FAIL cycle_low t=%0t: got pos=%b seg=%h dp=%b fd=%b, expected pos=%b seg=%h dp=%b fd=%b (seg checked=%0d)",
                     $time, bus_l.pos_out, bus_l.seg_out, bus_l.dp_out, bus_l.frame_done,
                     ~e_pos, e_seg ^ 7'h7F, ~e_dp, e_fd, e_segv);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
        bus_h.en = 1'b0;
        step(2);
        bus_h.digits = d;
        bus_h.dp     = dpv;
        bus_h.blank  = bl;
        bus_h.en     = 1'b1;
    endtask

    initial begin
        bus_h.en     = 1'b0;
        bus_h.digits = 16'h1A3F;
        bus_h.dp     = 4'b0000;
        bus_h.blank  = 4'b0000;
        step(3);
        rst_n = 1'b1;
        step(1);
        chk("reset_pos_h", 8'(bus_h.pos_out), 8'h0);
        chk("reset_seg_h", 8'(bus_h.seg_out), 8'h00);
        chk("reset_pos_l", 8'(bus_l.pos_out), 8'h0F);
        chk("reset_seg_l", 8'(bus_l.seg_out), 8'h7F);

        // Frame of 1A3F, then 2222 presented mid-frame.
        bus_h.en = 1'b1;
        step(2);
        chk("slot0_pos_h", 8'(bus_h.pos_out), 8'h01);
        chk("slot0_seg_h", 8'(bus_h.seg_out), 8'h71);
        chk("slot0_pos_l", 8'(bus_l.pos_out), 8'h0E);
        chk("slot0_seg_l", 8'(bus_l.seg_out), 8'h0E);
        step(5);
        chk("slot0_last_seg", 8'(bus_h.seg_out), 8'h71);
        step(1);
        chk("gap0_pos", 8'(bus_h.pos_out), 8'h0);
        chk("gap0_seg", 8'(bus_h.seg_out), 8'h00);
        step(2);
        chk("slot1_pos", 8'(bus_h.pos_out), 8'h02);
        chk("slot1_seg", 8'(bus_h.seg_out), 8'h4F);
        step(1);
        bus_h.digits = 16'h2222;
        step(7);
        chk("slot2_pos", 8'(bus_h.pos_out), 8'h04);
        chk("slot2_seg_old", 8'(bus_h.seg_out), 8'h77);
        step(8);
        chk("slot3_pos", 8'(bus_h.pos_out), 8'h08);
        chk("slot3_seg_old", 8'(bus_h.seg_out), 8'h06);
        step(6);
        chk("fd_before", 8'(bus_h.frame_done), 8'h0);
        step(1);
        chk("fd_first", 8'(bus_h.frame_done), 8'h1);
        step(1);
        chk("fd_single", 8'(bus_h.frame_done), 8'h0);
        chk("new_snap_seg", 8'(bus_h.seg_out), 8'h5B);
        step(30);
        chk("fd_gap31", 8'(bus_h.frame_done), 8'h0);
        step(1);
        chk("fd_second", 8'(bus_h.frame_done), 8'h1);

        // Drop en during slot 2, then restart with fresh data.
        step(18);
        chk("pre_drop_pos", 8'(bus_h.pos_out), 8'h04);
        bus_h.en = 1'b0;
        step(1);
        chk("drop_lag_pos", 8'(bus_h.pos_out), 8'h04);
        step(1);
        chk("drop_off_pos", 8'(bus_h.pos_out), 8'h0);
        chk("drop_off_seg", 8'(bus_h.seg_out), 8'h00);
        bus_h.digits = 16'h4321;
        bus_h.en     = 1'b1;
        step(2);
        chk("restart_pos", 8'(bus_h.pos_out), 8'h01);
        chk("restart_seg", 8'(bus_h.seg_out), 8'h06);
        step(8);
        chk("restart_slot1", 8'(bus_h.seg_out), 8'h5B);

        // Leading zeros.
        restart(16'h0005, 4'b0000, 4'b0000);
        step(2);
        chk("lz5_slot0_seg", 8'(bus_h.seg_out), 8'h6D);
        step(8);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        chk("lz5_slot1_pos", 8'(bus_h.pos_out), 8'h0);
        step(16);
        chk("lz5_slot3_pos", 8'(bus_h.pos_out), 8'h0);
`else
        chk("lz5_slot1_pos", 8'(bus_h.pos_out), 8'h02);
        chk("lz5_slot1_seg", 8'(bus_h.seg_out), 8'h3F);
        step(16);
        chk("lz5_slot3_pos", 8'(bus_h.pos_out), 8'h08);
        chk("lz5_slot3_seg", 8'(bus_h.seg_out), 8'h3F);
`endif
        restart(16'h0000, 4'b0000, 4'b0000);
        step(2);
        chk("lz0_slot0_pos", 8'(bus_h.pos_out), 8'h01);
        chk("lz0_slot0_seg", 8'(bus_h.seg_out), 8'h3F);
        step(8);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        chk("lz0_slot1_pos", 8'(bus_h.pos_out), 8'h0);
`else
        chk("lz0_slot1_pos", 8'(bus_h.pos_out), 8'h02);
`endif
        restart(16'h0005, 4'b0100, 4'b0000);
        step(18);
        chk("dp_slot2_pos", 8'(bus_h.pos_out), 8'h04);
        chk("dp_slot2_seg", 8'(bus_h.seg_out), 8'h3F);
        chk("dp_slot2_dp", 8'(bus_h.dp_out), 8'h1);

        // Blank input, then asynchronous reset in the middle of a lit slot.
        restart(16'h1234, 4'b0000, 4'b0010);
        step(2);
        chk("blank_slot0_seg", 8'(bus_h.seg_out), 8'h66);
        step(8);
        chk("blank_slot1_pos", 8'(bus_h.pos_out), 8'h0);
        step(8);
        chk("blank_slot2_seg", 8'(bus_h.seg_out), 8'h5B);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pos_h", 8'(bus_h.pos_out), 8'h0);
        chk("async_seg_h", 8'(bus_h.seg_out), 8'h00);
        chk("async_dp_h", 8'(bus_h.dp_out), 8'h0);
        chk("async_fd_h", 8'(bus_h.frame_done), 8'h0);
        chk("async_pos_l", 8'(bus_l.pos_out), 8'h0F);
        chk("async_seg_l", 8'(bus_l.seg_out), 8'h7F);
        step(2);
        rst_n = 1'b1;
        step(4);
        bus_h.en = 1'b0;
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
